// File: rtl/fetch_halfword_aligner_pkg.sv
// Shared types and helpers for the fetch halfword aligner.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WAIT_DISCARD} fetch_state_t;

  localparam int HW_W = 16;

  function automatic logic is_compressed(input logic [HW_W-1:0] hw);
    return hw[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/fetch_halfword_aligner_fifo.sv
// Halfword FIFO: shift-register storage with the head always at slot 0,
// push/pop of one or two entries per cycle and a synchronous flush.
module halfword_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = HW_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [1:0]                   push_n,
  input  logic [1:0][W-1:0]            push_data,
  input  logic [1:0]                   pop_n,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [W-1:0]                 head0,
  output logic [W-1:0]                 head1
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] mem, mem_nxt;
  logic [CW-1:0]           base;

  // Pop shifts the survivors down first; pushes land right after them.
  always_comb begin
    base    = count - CW'(pop_n);
    mem_nxt = mem >> (W * int'(pop_n));
    for (int i = 0; i < DEPTH; i++) begin
      if (push_n != 2'd0 && CW'(i) == base)          mem_nxt[i] = push_data[0];
      if (push_n == 2'd2 && CW'(i) == base + CW'(1)) mem_nxt[i] = push_data[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      mem   <= mem_nxt;
      count <= base + CW'(push_n);
    end
  end

  assign head0 = mem[0];
  assign head1 = mem[1];
endmodule

// File: rtl/fetch_halfword_aligner.sv
// Fetch aligner: word reads in, whole 16/32-bit instructions out.
// Optional access-fault tracking is enabled with `define FETCH_ACCESS_FAULT_EN.
module fetch_halfword_aligner #(
  parameter int          BUF_HW   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        ResetN,
  output logic        FetchReq,
  output logic [31:0] FetchAddr,
  input  logic        FetchGnt,
  input  logic        FetchRValid,
  input  logic [31:0] FetchRData,
`ifdef FETCH_ACCESS_FAULT_EN
  input  logic        FetchRErr,
  output logic        InstrFault,
`endif
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrData,
  output logic        InstrCompressed,
  output logic [31:0] InstrPC,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC
);
  import fetch_pkg::*;

  localparam int CW = $clog2(BUF_HW+1);
`ifdef FETCH_ACCESS_FAULT_EN
  localparam int EW = HW_W + 1;
`else
  localparam int EW = HW_W;
`endif

  fetch_state_t        state;
  logic                drop_low;
  logic [31:0]         head_pc;
  logic [CW-1:0]       count;
  logic [EW-1:0]       head0, head1;
  logic [HW_W-1:0]     hw0, hw1;
  logic                flt0, flt1;
  logic                one_hw, fault_instr, accept, rsp_take, fetch_stop;
  logic [1:0]          push_n, pop_n;
  logic [1:0][EW-1:0]  push_data;
  logic [HW_W-1:0]     rsp_lo, rsp_hi;

  assign rsp_lo = FetchRData[15:0];
  assign rsp_hi = FetchRData[31:16];

`ifdef FETCH_ACCESS_FAULT_EN
  logic faulted;
  assign push_data[0] = {FetchRErr, drop_low ? rsp_hi : rsp_lo};
  assign push_data[1] = {FetchRErr, rsp_hi};
  assign flt0         = head0[HW_W];
  assign flt1         = head1[HW_W];
  assign fetch_stop   = faulted;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)                    faulted <= 1'b0;
    else if (Redirect)              faulted <= 1'b0;
    else if (rsp_take && FetchRErr) faulted <= 1'b1;
  end
`else
  assign push_data[0] = drop_low ? rsp_hi : rsp_lo;
  assign push_data[1] = rsp_hi;
  assign flt0         = 1'b0;
  assign flt1         = 1'b0;
  assign fetch_stop   = 1'b0;
`endif

  assign hw0 = head0[HW_W-1:0];
  assign hw1 = head1[HW_W-1:0];

  // A faulted head is presented alone so a bad parcel can never stall waiting for a partner.
  assign one_hw      = is_compressed(hw0) | flt0;
  assign fault_instr = flt0 | (~one_hw & flt1);

  assign InstrValid      = one_hw ? (count != '0) : (count >= CW'(2));
  assign InstrCompressed = InstrValid & one_hw;
  assign InstrPC         = head_pc;
  assign InstrData       = (!InstrValid || fault_instr) ? 32'h0 :
                           one_hw ? {16'h0, hw0} : {hw1, hw0};
`ifdef FETCH_ACCESS_FAULT_EN
  assign InstrFault      = InstrValid & fault_instr;
`endif

  assign accept   = InstrValid & InstrReady & ~Redirect;
  assign pop_n    = !accept ? 2'd0 : (one_hw ? 2'd1 : 2'd2);
  assign rsp_take = (state == WAIT) & FetchRValid & ~Redirect;
  assign push_n   = !rsp_take ? 2'd0 : (drop_low ? 2'd1 : 2'd2);

  halfword_fifo #(.DEPTH(BUF_HW), .W(EW)) u_fifo (
    .clk       (Clk),
    .rst_n     (ResetN),
    .flush     (Redirect),
    .push_n    (push_n),
    .push_data (push_data),
    .pop_n     (pop_n),
    .count     (count),
    .head0     (head0),
    .head1     (head1)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state     <= IDLE;
      FetchReq  <= 1'b0;
      FetchAddr <= RESET_PC & 32'hFFFF_FFFC;
      drop_low  <= RESET_PC[1];
      head_pc   <= RESET_PC & 32'hFFFF_FFFE;
    end else begin
      if (Redirect) begin
        FetchAddr <= RedirectPC & 32'hFFFF_FFFC;
        drop_low  <= RedirectPC[1];
        head_pc   <= RedirectPC & 32'hFFFF_FFFE;
      end else begin
        if (accept) head_pc <= head_pc + (one_hw ? 32'd2 : 32'd4);
        if (rsp_take) begin
          FetchAddr <= FetchAddr + 32'd4;
          drop_low  <= 1'b0;
        end
      end

      case (state)
        IDLE:
          if (!Redirect && !fetch_stop && count <= CW'(BUF_HW-2)) begin
            state    <= REQ;
            FetchReq <= 1'b1;
          end
        REQ:
          // A grant coinciding with a redirect is for the old address.
          if (FetchGnt) begin
            state    <= Redirect ? WAIT_DISCARD : WAIT;
            FetchReq <= 1'b0;
          end
        WAIT:
          if (Redirect)         state <= FetchRValid ? IDLE : WAIT_DISCARD;
          else if (FetchRValid) state <= IDLE;
        WAIT_DISCARD:
          if (FetchRValid) begin
            state    <= REQ;
            FetchReq <= 1'b1;
          end
        default: begin
          state    <= IDLE;
          FetchReq <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/fetch_halfword_aligner.md
Name: fetch_halfword_aligner

Overview:
Fetch-side stage directly upstream of the compressed-instruction decoder in the RV32EC core. It issues word-aligned 32-bit reads to instruction memory and buffers the returned data as 16-bit halfword parcels. It presents one complete instruction per handshake: a 16-bit compressed instruction, or a 32-bit instruction that may straddle a word boundary, together with its PC. It also handles PC redirects from branches and jumps, including redirects to halfword-aligned targets.

Parameters:
BUF_HW, 4, halfword buffer depth; legal values are 4 and 6.
RESET_PC, 32'h0000_0000, fetch address after reset; bit 0 is ignored.

Ports:
Clk  in  1  core clock
ResetN  in  1  asynchronous active-low reset
FetchReq  out  1  read request; held until FetchGnt
FetchAddr  out  32  word-aligned read address; bits [1:0] are always 0
FetchGnt  in  1  request accepted this cycle
FetchRValid  in  1  read data valid; at most one per accepted request
FetchRData  in  32  read data, little-endian
InstrValid  out  1  an instruction is presented
InstrReady  in  1  downstream accepts the instruction
InstrData  out  32  instruction; compressed form is zero-extended from 16 bits
InstrCompressed  out  1  1 if InstrData[1:0] != 2'b11
InstrPC  out  32  halfword-aligned PC of the instruction
Redirect  in  1  flush the buffer and restart fetch
RedirectPC  in  32  new PC; bit 0 is ignored

Behaviour:
- Reset values: FetchReq=0, FetchAddr=RESET_PC&~3, InstrValid=0, InstrData=0, InstrCompressed=0, InstrPC=RESET_PC&~1. Buffer count=0, state IDLE, DropLow=RESET_PC[1].
- Fetch FSM states: IDLE, REQ, WAIT, WAIT_DISCARD. At most one read is outstanding.
- IDLE->REQ when free slots >= 2 and Redirect=0.
- REQ drives FetchReq=1. REQ->WAIT on FetchGnt. FetchAddr and FetchReq stay stable until the grant.
- WAIT->IDLE on FetchRValid. The word is written to the buffer as two halfwords, low first. FetchAddr then advances by 4.
- DropLow: if set, only the high halfword is written and DropLow clears.
- Redirect: takes priority over every other event in the same cycle.
  - Clears the buffer and sets FetchAddr=RedirectPC&~3, DropLow=RedirectPC[1], and the buffer head PC to RedirectPC&~1.
  - Redirect in REQ: FetchReq stays asserted but the address is updated; a grant arriving that same cycle goes to WAIT_DISCARD.
  - Redirect in WAIT: goes to WAIT_DISCARD.
- WAIT_DISCARD: the next FetchRValid is dropped, then the FSM goes to REQ.
- Output conditions:
  - Head halfword bits [1:0] != 11 and count >= 1: present compressed.
  - Head bits [1:0] == 11 and count >= 2: present {hw1, hw0}.
  - Otherwise InstrValid=0.
- Output is combinational from the buffer head. It stays stable while InstrValid=1 and InstrReady=0 (no new data reaches the head).
- Accept (InstrValid & InstrReady & ~Redirect): pop 1 or 2 halfwords and advance the head PC by 2 or 4, modulo 2^32.
- Same-cycle pop and fill: both take effect. Count_next = count - pop + push, and never exceeds BUF_HW by construction.
- Straddling instruction: the upper halfword arrives in a later word. The instruction is not presented until it arrives; no partial output.
- Reset mid-operation: any outstanding read is forgotten. The memory shares ResetN, so a stale FetchRValid cannot occur.

Optional Feature:
Macro FETCH_ACCESS_FAULT_EN.
- Enabled:
  - Adds input FetchRErr (valid with FetchRValid) and output InstrFault.
  - A faulting word is buffered with a per-halfword fault bit.
  - An instruction whose halfwords include a faulted one is presented with InstrFault=1 and InstrData=0.
  - Fetching stops (FSM held in IDLE) until Redirect.
- Disabled: these ports and bits are absent, and all data is treated as good.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT, WAIT_DISCARD}
  - localparam HW_W=16
  - function is_compressed(hw) returning hw[1:0]!=2'b11
- One sub-module: halfword_fifo. Parameterised depth, push of 1 or 2 halfwords, pop of 1 or 2, flush, count output, peek at head and head+1.

Test Plan:
- Reset then ready=1; memory returns 32'h0001_4501 → two compressed instructions: 16'h4501 at PC 0x0, then 16'h0001 at PC 0x2; FetchAddr advances 0x0→0x4.
- Word0=32'h0093_4501, word1=32'h1234_0010 → 16'h4501 at PC 0x0, then 32-bit 32'h0010_0093 at PC 0x2 presented only after word1 returns, then 16'h1234 at PC 0x6.
- Redirect to 0x102 in IDLE → FetchAddr=0x100; the low halfword of the returned word is dropped; the first InstrPC=0x102.
- Redirect while in WAIT → the in-flight FetchRValid is discarded; the next request is at the redirect word; no stale instruction is ever presented.
- InstrReady held low for 10 cycles → buffer fills to BUF_HW, FetchReq deasserts, and InstrData/InstrPC stay constant.
- (FETCH_ACCESS_FAULT_EN) FetchRErr=1 on the second word → the first word's instructions are normal, then InstrFault=1 with InstrData=0, and no FetchReq until Redirect.
